// File: rtl/game_display_if.sv
// game_display_if: bundles the game-side snapshot inputs and the
// 7-segment outputs of game_display.
//   player[1:0]      current player index 0..3
//   position[3:0]    current player position
//   status_code[3:0] current player status (9..15 = win)
//   an[3:0]          digit enables, active-low, an[0] rightmost
//   seg[6:0]         segments, active-low, {g,f,e,d,c,b,a}
// master drives the game values and watches the display; slave is the driver.
interface game_display_if;
  logic [1:0] player;
  logic [3:0] position;
  logic [3:0] status_code;
  logic [3:0] an;
  logic [6:0] seg;

  modport master (output player, position, status_code, input an, seg);
  modport slave  (input player, position, status_code, output an, seg);
endinterface

// File: rtl/game_display.sv
// game_display: four-digit multiplexed common-anode 7-segment driver.
// Snapshots player/position/status once per frame and scans them out as
//   digit3 = player+1, digit2 = blank, digit1 = position, digit0 = status.
// The whole display blinks while the captured status is a win (> 8).
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   dif  game_display_if.slave (player/position/status_code in, an/seg out)
// Parameters:
//   SCAN_DIV   clk cycles per digit slot (2..16383)
//   BLINK_DIV  frames per blink half-period (1..255)
module game_display #(
  parameter int SCAN_DIV  = 2500,
  parameter int BLINK_DIV = 25
) (
  input logic          clk,
  input logic          rst,
  game_display_if.slave dif
);

  logic [13:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]  digit_idx_q, digit_idx_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        blink_phase_q, blink_phase_d;
  logic [1:0]  sh_player_q, sh_player_d;
  logic [3:0]  sh_pos_q, sh_pos_d;
  logic [3:0]  sh_status_q, sh_status_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;

  logic        scan_end, frame_end, blank;
  logic [2:0]  player_num;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    scan_end  = (scan_cnt_q == 14'(SCAN_DIV - 1));
    frame_end = scan_end && (digit_idx_q == 2'd3);

    scan_cnt_d    = scan_end ? 14'd0 : scan_cnt_q + 14'd1;
    digit_idx_d   = scan_end ? digit_idx_q + 2'd1 : digit_idx_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    sh_player_d   = sh_player_q;
    sh_pos_d      = sh_pos_q;
    sh_status_d   = sh_status_q;

    // Capture and blink toggle share the frame-end cycle, so the next
    // frame starts with both the new snapshot and the new phase.
    if (frame_end) begin
      sh_player_d = dif.player;
      sh_pos_d    = dif.position;
      sh_status_d = dif.status_code;
      if (frame_cnt_q == 8'(BLINK_DIV - 1)) begin
        frame_cnt_d   = 8'd0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end

    // Outputs are one clk behind digit_idx/shadow: decode current state.
    player_num = {1'b0, sh_player_q} + 3'd1;
    blank      = (sh_status_q > 4'd8) && blink_phase_q;

    an_d = ~(4'b0001 << digit_idx_q);
    case (digit_idx_q)
      2'd0:    seg_d = hex7(sh_status_q);
      2'd1:    seg_d = hex7(sh_pos_q);
      2'd2:    seg_d = 7'h7F;
      default: seg_d = hex7({1'b0, player_num});
    endcase
    if (blank) begin
      an_d  = 4'b1111;
      seg_d = 7'h7F;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q    <= '0;
      digit_idx_q   <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      sh_player_q   <= '0;
      sh_pos_q      <= '0;
      sh_status_q   <= '0;
      an_q          <= 4'b1111;
      seg_q         <= 7'h7F;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      digit_idx_q   <= digit_idx_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      sh_player_q   <= sh_player_d;
      sh_pos_q      <= sh_pos_d;
      sh_status_q   <= sh_status_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
    end
  end

  assign dif.an  = an_q;
  assign dif.seg = seg_q;

endmodule
